// File: rtl/ofmap_serializer.sv
// rtl/ofmap_serializer.sv - serializes a NUM_INPUTS-lane ReLU output vector into one value per beat
// Also counts zero-valued output beats (saturating) for sparsity statistics.
module ofmap_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready,
  input  logic                             stat_clear,
  output logic [CNT_WIDTH-1:0]             zero_cnt
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] vec_q, vec_d;
  logic                             last_q, last_d;
  logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
  logic                             at_last;
  logic                             in_fire;
  logic                             out_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    at_last   = (idx_q == LAST_IDX);

    case (state_q)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        out_valid = 1'b1;
        out_data  = vec_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
        out_last  = at_last & last_q;
        // Reload on the final beat so a continuous stream has no bubble.
        in_ready  = at_last & out_ready;
      end
    endcase

    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;

    if (in_fire) begin
      state_d = BUSY;
      idx_d   = '0;
      vec_d   = in_data;
      last_d  = in_last;
    end else if (out_fire) begin
      if (at_last) state_d = IDLE;
      else         idx_d   = idx_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stat_clear)
      cnt_d = '0;
    else if (out_fire && (out_data == '0) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  assign zero_cnt = cnt_q;

endmodule

// File: tb/tb_ofmap_serializer.sv
// tb/tb_ofmap_serializer.sv - self-checking bench for ofmap_serializer
// A queue of pending beats models the block; directed vectors pin literal values.
module tb_ofmap_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        stat_clear = 1'b0;
  logic [15:0] zero_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats_xfer = 0;

  logic [15:0] exp_d[$];
  bit          exp_l[$];
  logic [15:0] mcnt = '0;

  ofmap_serializer #(.DATA_WIDTH(16), .NUM_INPUTS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .stat_clear(stat_clear), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining beats of the held vector; in_ready follows from how many remain.
  always @(negedge clk) begin
    int          sz;
    bit          xfer, rdy;
    logic [15:0] beat;
    if (reset) begin
      exp_d.delete();
      exp_l.delete();
      mcnt = '0;
      check("rst_out_valid", out_valid, 0);
      check("rst_zero_cnt", zero_cnt, 0);
    end else begin
      sz   = exp_d.size();
      xfer = (sz != 0) && out_ready;
      rdy  = (sz == 0) || (sz == 1 && out_ready);
      check("m_out_valid", out_valid, (sz != 0));
      if (sz != 0) begin
        check("m_out_data", out_data, exp_d[0]);
        check("m_out_last", out_last, exp_l[0]);
      end
      check("m_in_ready", in_ready, rdy);
      check("m_zero_cnt", zero_cnt, mcnt);
      beat = 16'hFFFF;
      if (xfer) begin
        beat = exp_d.pop_front();
        void'(exp_l.pop_front());
        beats_xfer++;
      end
      if (stat_clear) mcnt = '0;
      else if (xfer && beat == 16'h0 && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (in_valid && rdy) begin
        for (int i = 0; i < 4; i++) begin
          exp_d.push_back(in_data[i*16 +: 16]);
          exp_l.push_back((i == 3) && in_last);
        end
      end
    end
  end

  task automatic send(input logic [63:0] v, input logic l);
    bit hs;
    int n;
    in_data  = v;
    in_last  = l;
    in_valid = 1'b1;
    hs = 0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 64'hDEAD_BEEF_CAFE_F00D;
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=no_handshake required=handshake at %0t", $time);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle", out_valid, 0);
  endtask

  initial begin
    int c1, c3, b0;
    logic [15:0] lane;

    #1 reset = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", out_data, 0);
    check("reset_zero_cnt", zero_cnt, 0);
    @(posedge clk); #1 reset = 1'b0;
    check("post_reset_in_ready", in_ready, 1);

    // Single vector
    send(64'h0004_0003_0002_0001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      lane = 16'(i + 1);
      check("single_valid", out_valid, 1);
      check("single_data", out_data, lane);
      check("single_last", out_last, (i == 3));
      @(posedge clk); #1;
    end
    check("single_idle_valid", out_valid, 0);
    check("single_idle_ready", in_ready, 1);

    // Back-to-back, no bubbles
    send(64'h0013_0012_0011_0010, 1'b0);
    c1 = cyc;
    b0 = beats_xfer;
    send(64'h0023_0022_0021_0020, 1'b0);
    send(64'h0033_0032_0031_0030, 1'b1);
    c3 = cyc;
    check("b2b_accept_spacing", 64'(c3 - c1), 8);
    repeat (5) begin @(posedge clk); #1; end
    check("b2b_beats", 64'(beats_xfer - b0), 12);
    check("b2b_idle", out_valid, 0);

    // Backpressure on lane 1
    b0 = beats_xfer;
    send(64'h0004_0003_0002_0001, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_data", out_data, 16'h0002);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_idle();
    check("bp_beats", 64'(beats_xfer - b0), 4);

    // Zero statistics
    stat_clear = 1'b1;
    @(posedge clk); #1 stat_clear = 1'b0;
    check("zc_cleared", zero_cnt, 0);
    send(64'h0000_0005_0000_0000, 1'b1);
    wait_idle();
    check("zc_three", zero_cnt, 3);
    for (int i = 0; i < 16384; i++) send(64'h0, (i == 16383));
    wait_idle();
    check("zc_saturated", zero_cnt, 16'hFFFF);
    send(64'h0, 1'b1);
    stat_clear = 1'b1;
    @(posedge clk); #1 stat_clear = 1'b0;
    check("zc_clear_prio", zero_cnt, 0);
    wait_idle();
    check("zc_after_clear", zero_cnt, 3);

    // Reset mid-vector
    send(64'h0004_0003_0002_0001, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_zero_cnt", zero_cnt, 0);
    check("midrst_out_last", out_last, 0);
    @(posedge clk); #1 reset = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    send(64'h000D_000C_000B_000A, 1'b1);
    check("midrst_first_beat", out_data, 16'h000A);
    check("midrst_first_valid", out_valid, 1);
    wait_idle();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
